// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data RAM between CPU memory stage and debug port; optional counters via DMEM_ARB_STATS_EN
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]           stat_cpu_grants,
  output logic [15:0]           stat_dbg_grants,
  output logic [15:0]           stat_stall_cycles,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t        state;
  logic          owner_dbg;
  logic [CW-1:0] beat;
  logic [SW-1:0] starve_cnt;
  logic          start, pick_dbg, starved;
  assign starved   = starve_cnt == SW'(STARVE_LIMIT);
  assign start     = state == IDLE && (cpu_req || dbg_req);
  assign pick_dbg  = dbg_req && (!cpu_req || starved);
  assign cpu_stall = cpu_req && !(state == RESP && !owner_dbg);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner_dbg  <= 1'b0;
      beat       <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      dbg_ack    <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= BUSY;
          owner_dbg  <= pick_dbg;
          beat       <= CW'(MEM_LATENCY - 1);
          mem_en     <= 1'b1;
          mem_we     <= pick_dbg ? dbg_we : cpu_we;
          mem_addr   <= pick_dbg ? dbg_addr : cpu_addr;
          mem_wdata  <= pick_dbg ? dbg_wdata : cpu_wdata;
          starve_cnt <= pick_dbg ? '0 : (dbg_req && !starved) ? starve_cnt + 1'b1 : starve_cnt;
        end
        BUSY: if (beat == '0) begin
          if (!mem_we && owner_dbg) dbg_rdata <= mem_rdata;
          if (!mem_we && !owner_dbg) cpu_rdata <= mem_rdata;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          dbg_ack <= owner_dbg;
          state   <= RESP;
        end else begin
          beat <= beat - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cpu_grants   <= '0;
      stat_dbg_grants   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (start && !pick_dbg && stat_cpu_grants != '1) stat_cpu_grants <= stat_cpu_grants + 1'b1;
      if (start && pick_dbg && stat_dbg_grants != '1) stat_dbg_grants <= stat_dbg_grants + 1'b1;
      if (cpu_stall && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-timeline model checked every cycle
module tb_dmem_arbiter;
  localparam int ML = 2;
  localparam int SL = 4;
  logic        clock = 1'b0, reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_cpu_grants, stat_dbg_grants, stat_stall_cycles;
`endif
  logic [31:0] ram [256];
  logic [31:0] shadow [256];
  int          cyc = 0, checks = 0, errors = 0;
  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_cpu_grants(stat_cpu_grants), .stat_dbg_grants(stat_dbg_grants),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clock) if (mem_en && mem_we) ram[mem_addr[9:2]] <= mem_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Model: each granted access occupies cycles start..start+ML+1, with the last one as the response cycle.
  int          m_start = 0, m_idle_at = 0, m_starve = 0;
  bit          m_dbg, m_we;
  logic [31:0] m_addr, m_wdata, m_cpu_rd = '0, m_dbg_rd = '0;
  logic        e_en, e_we, e_ack, e_stall;
  always @(negedge clock) begin
    e_en = 1'b0; e_we = 1'b0; e_ack = 1'b0; e_stall = cpu_req;
    if (!reset) begin
      m_idle_at = cyc; m_starve = 0; m_cpu_rd = '0; m_dbg_rd = '0;
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
    end else if (cyc >= m_idle_at) begin
      if (cpu_req || dbg_req) begin
        m_dbg   = dbg_req && (!cpu_req || m_starve == SL);
        m_we    = m_dbg ? dbg_we : cpu_we;
        m_addr  = m_dbg ? dbg_addr : cpu_addr;
        m_wdata = m_dbg ? dbg_wdata : cpu_wdata;
        m_starve = m_dbg ? 0 : (dbg_req && m_starve < SL) ? m_starve + 1 : m_starve;
        m_start = cyc; m_idle_at = cyc + ML + 2;
      end
    end else if (cyc - m_start <= ML) begin
      e_en = 1'b1; e_we = m_we;
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end else begin
      if (m_we) shadow[m_addr[9:2]] = m_wdata;
      else if (m_dbg) m_dbg_rd = shadow[m_addr[9:2]];
      else m_cpu_rd = shadow[m_addr[9:2]];
      e_ack = m_dbg; e_stall = cpu_req && m_dbg;
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("dbg_ack", dbg_ack, e_ack);
    chk("cpu_stall", cpu_stall, e_stall);
    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("dbg_rdata", dbg_rdata, m_dbg_rd);
  end
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic cpu_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock); done = !cpu_stall; step();
    end
    cpu_req = 1'b0;
    chk("cpu_done", 32'(done), 32'd1);
  endtask
  task automatic dbg_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                            output int at, output logic [31:0] rd);
    bit done = 0;
    at = -1; rd = '0;
    dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (dbg_ack) begin done = 1; at = cyc; rd = dbg_rdata; end
      step();
    end
    dbg_req = 1'b0;
    chk("dbg_done", 32'(done), 32'd1);
  endtask
  initial begin
    int          n_stall, n_en, a1, a2, cpu_done, dbg_done, n;
    logic [31:0] rd;
    logic [9:0]  seq;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = (i == 2) ? 32'h2A : 32'hA500_0000 + 32'(i);
      shadow[i] = (i == 2) ? 32'h2A : 32'hA500_0000 + 32'(i);
    end
    repeat (3) step();
    reset = 1'b1;
    step();
    n_stall = 0; n_en = 0;
    cpu_we = 1'b0; cpu_addr = 32'h8; cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_stall += int'(cpu_stall); n_en += int'(mem_en);
      if (i == 3) rd = cpu_rdata;
      step();
    end
    cpu_req = 1'b0;
    chk("load_stall_cycles", 32'(n_stall), 32'd3);
    chk("load_en_cycles", 32'(n_en), 32'd2);
    chk("load_rdata", rd, 32'h2A);
    step();
    dbg_access(1'b1, 32'hC, 32'h1234_5678, a1, rd);
    dbg_access(1'b0, 32'hC, 32'h0, a2, rd);
    chk("dbg_ack_spacing", 32'(a2 - a1), 32'd4);
    chk("dbg_read_back", rd, 32'h1234_5678);
    step();
    cpu_we = 1'b0; cpu_addr = 32'h10; dbg_we = 1'b0; dbg_addr = 32'h14;
    cpu_req = 1'b1; dbg_req = 1'b1; seq = '0; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dbg_ack) begin seq = {seq[8:0], 1'b1}; n++; end
      else if (cpu_req && !cpu_stall) begin seq = {seq[8:0], 1'b0}; n++; end
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("grant_seq", 32'(seq), 32'b00_0010_0001);
    chk("grant_count", 32'(n), 32'd10);
    repeat (2) step();
    cpu_addr = 32'h8; dbg_addr = 32'hC; cpu_req = 1'b1; dbg_req = 1'b1;
    cpu_done = -1; dbg_done = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (cpu_req && !cpu_stall) cpu_done = i;
      if (dbg_ack) dbg_done = i;
      step();
      if (i == cpu_done) cpu_req = 1'b0;
      if (i == dbg_done) dbg_req = 1'b0;
    end
    chk("simul_cpu_done", 32'(cpu_done), 32'd3);
    chk("simul_dbg_done", 32'(dbg_done), 32'd7);
    step();
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF; cpu_req = 1'b1;
    step();
    chk("busy_mem_en", 32'(mem_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("rst_stall_req1", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    #1;
    chk("rst_stall_req0", 32'(cpu_stall), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_stall", 32'(cpu_stall), 32'(cpu_req));
    chk("post_rst_ack", 32'(dbg_ack), 32'd0);
    step();
    for (int i = 0; i < 3; i++) cpu_access(1'b0, 32'h8 + 32'(4 * i), 32'h0);
    dbg_access(1'b0, 32'hC, 32'h0, a1, rd);
    chk("dbg_read_after_rst", rd, 32'h1234_5678);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_cpu_grants", 32'(stat_cpu_grants), 32'd3);
    chk("stat_dbg_grants", 32'(stat_dbg_grants), 32'd1);
    chk("stat_stall_cycles", 32'(stat_stall_cycles), 32'd9);
`endif
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data RAM between two requesters: the CPU memory stage (lw/sw) and a debug/loader port that preloads or dumps data memory while the core runs.
- Sits between the MEMORY stage and the data RAM instance.
- Generates the pipeline stall and enforces a starvation bound for the debug port.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requesters and the RAM.
- DATA_WIDTH, 32, data word width.
- MEM_LATENCY, 2, cycles the RAM control signals are held per access; minimum 1.
- STARVE_LIMIT, 4, consecutive CPU grants with debug pending before debug is forced; minimum 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held stable while cpu_stall=1.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU store data.
- cpu_rdata  out  DATA_WIDTH  CPU load data; valid in the CPU RESP cycle.
- cpu_stall  out  1  freezes the pipeline.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_WIDTH  debug address.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_rdata  out  DATA_WIDTH  debug read data; valid while dbg_ack=1.
- dbg_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data; valid by the last cycle of an access.

Behaviour:
- Reset (async, reset=0):
  - state = IDLE.
  - mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dbg_rdata, dbg_ack and the starve counter all = 0.
  - An access in flight is aborted: mem_we drops immediately and no ack is issued.
- States:
  - IDLE to BUSY: on any pending request. The winner's we, addr and wdata are registered onto mem_*, mem_en=1, the owner is recorded, and the beat counter is set to MEM_LATENCY-1.
  - BUSY: mem_* held constant; the counter decrements each cycle. When the counter reaches 0, mem_rdata is captured into the owner's rdata register (loads only; writes leave rdata unchanged), mem_en and mem_we are cleared, and the state moves to RESP.
  - RESP to IDLE: lasts one cycle. If the owner is debug, dbg_ack=1. If the owner is the CPU, cpu_stall=0 this cycle.
- Arbitration (evaluated in IDLE only):
  - Only one requester: it wins.
  - Both requesting: the CPU wins unless starve_cnt == STARVE_LIMIT, in which case debug wins.
  - starve_cnt increments on each CPU grant made while dbg_req=1, saturating at STARVE_LIMIT. It clears on any debug grant.
- cpu_stall is combinational: cpu_req AND NOT (state==RESP AND owner==CPU). With cpu_req=0 it is 0, including during reset.
- Timing:
  - CPU request first seen in IDLE at cycle 0 completes in cycle MEM_LATENCY+1.
  - Stall is high for cycles 0..MEM_LATENCY.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requests arriving during BUSY or RESP wait for IDLE; requests are not queued beyond the held input level.
- A dbg_req dropped before ack violates protocol and is ignored once granted; the access completes anyway.
- Addresses pass through unmodified; word alignment is the RAM's concern.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_cpu_grants (16), stat_dbg_grants (16) and stat_stall_cycles (16).
  - All three are saturating counters, reset to 0 by reset.
  - stat_stall_cycles counts cycles with cpu_stall=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=4):
- CPU load from 0x8 with the RAM holding 0x0000002A: cpu_stall high for 3 cycles, cpu_rdata=0x2A in the 4th cycle, mem_en high for exactly 2 cycles.
- Debug write 0x12345678 to 0xC, then debug read of 0xC: dbg_ack pulses once per access, 4 cycles apart; the read returns 0x12345678.
- cpu_req and dbg_req held continuously: grant sequence CPU,CPU,CPU,CPU,DBG, repeating; starve_cnt returns to 0 after each debug grant.
- Simultaneous single requests with starve_cnt=0: CPU granted first; debug is granted in the next IDLE (cycle 4) and acked in cycle 7.
- reset pulsed low during BUSY of a CPU store: mem_en and mem_we are 0 immediately; after release, state is IDLE, no ack, cpu_stall equals cpu_req.
- With DMEM_ARB_STATS_EN, 3 CPU loads and 1 debug read: stat_cpu_grants=3, stat_dbg_grants=1, stat_stall_cycles=9.
